// File: rtl/cnn_cnt_pkg.sv
// ---------------------------------------------------------------------------
// cnn_cnt_pkg
// Shared types for the address sequence counter slice.
//   clr_state_t : clear-handshake FSM states.
//     ARMED : a clear request is accepted.
//     LOCK  : clr is held high after an accepted clear and is ignored
//             until it drops.
// The optional saturating build is selected with macro ADDR_CNT_SAT_EN.
// ---------------------------------------------------------------------------
package cnn_cnt_pkg;

    typedef enum logic {
        ARMED = 1'b0,
        LOCK  = 1'b1
    } clr_state_t;

endpackage

// File: rtl/cnt_channel.sv
// ---------------------------------------------------------------------------
// cnt_channel
// This is one counter channel of addr_seq_counter. Each cycle it applies one
// action, in this priority order:
//   clear > load > advance > hold.
// The count always stays below DEPTH.
//
// Configuration macro ADDR_CNT_SAT_EN:
//   undefined : an advance from DEPTH-1 wraps to 0, and wrap_o pulses for
//               one cycle.
//   defined   : an advance from DEPTH-1 holds at DEPTH-1, and wrap_o is a
//               level flag that is high while count_o == DEPTH-1.
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : synchronous reset, active-low
//   clr_i    : clear this channel (already qualified by the handshake FSM)
//   load_i   : load this channel
//   load_val : load value; values >= DEPTH are clamped to DEPTH-1
//   en_i     : advance enable
//   count_o  : current count
//   wrap_o   : wrap indication (see the macro description above)
// ---------------------------------------------------------------------------
module cnt_channel #(
    parameter int CNT_W = 8,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             wrap_o
);

    localparam logic [CNT_W-1:0] TOP = CNT_W'(DEPTH - 1);

    // DEPTH may be 2**CNT_W, so compare with one extra bit.
    function automatic logic [CNT_W-1:0] clamp_load(input logic [CNT_W-1:0] v);
        if ({1'b0, v} >= (CNT_W + 1)'(DEPTH))
            return TOP;
        else
            return v;
    endfunction

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
`ifndef ADDR_CNT_SAT_EN
    logic             wrap_evt;
    logic             wrap_q;
`endif

    always_comb begin
        count_nxt = count;
`ifndef ADDR_CNT_SAT_EN
        wrap_evt  = 1'b0;
`endif
        if (clr_i) begin
            count_nxt = '0;
        end else if (load_i) begin
            count_nxt = clamp_load(load_val);
        end else if (en_i) begin
            if (count == TOP) begin
`ifdef ADDR_CNT_SAT_EN
                count_nxt = TOP;
`else
                count_nxt = '0;
                wrap_evt  = 1'b1;
`endif
            end else begin
                count_nxt = count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
`ifndef ADDR_CNT_SAT_EN
            wrap_q <= 1'b0;
`endif
        end else begin
            count  <= count_nxt;
`ifndef ADDR_CNT_SAT_EN
            wrap_q <= wrap_evt;
`endif
        end
    end

    assign count_o = count;
`ifdef ADDR_CNT_SAT_EN
    assign wrap_o  = (count == TOP);
`else
    assign wrap_o  = wrap_q;
`endif

endmodule

// File: rtl/addr_seq_counter.sv
// ---------------------------------------------------------------------------
// addr_seq_counter
// This module contains N_CH independent address counters. Each counter
// counts modulo DEPTH. A clear or a load goes to the channel selected by
// ch_sel. A clear handshake FSM accepts one clear for each rising edge of
// clr.
//
// Optional build macro ADDR_CNT_SAT_EN: the counters saturate at DEPTH-1
// instead of wrapping, and wrap becomes a level flag.
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : synchronous reset, active-low
//   ch_sel   : target channel for clr/load
//   clr      : clear request for channel ch_sel
//   load     : load request for channel ch_sel
//   load_val : load value (clamped to DEPTH-1)
//   en       : per-channel advance enable
//   count    : channel i is at [i*CNT_W +: CNT_W]
//   wrap     : per-channel wrap indication
//   clr_ack  : one-cycle acknowledge of an accepted clear
// ---------------------------------------------------------------------------
module addr_seq_counter
    import cnn_cnt_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int DEPTH = 256,
    parameter int N_CH  = 4,
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SEL_W-1:0]      ch_sel,
    input  logic                  clr,
    input  logic                  load,
    input  logic [CNT_W-1:0]      load_val,
    input  logic [N_CH-1:0]       en,
    output logic [N_CH*CNT_W-1:0] count,
    output logic [N_CH-1:0]       wrap,
    output logic                  clr_ack
);

    clr_state_t      state;
    clr_state_t      state_nxt;
    logic            clr_acc;
    logic [N_CH-1:0] clr_sel;
    logic [N_CH-1:0] load_sel;

    // A clear is accepted only in ARMED. While in LOCK, clr is treated as
    // absent, so load and en for the selected channel still apply.
    always_comb begin
        state_nxt = state;
        clr_acc   = 1'b0;
        case (state)
            ARMED: begin
                if (clr) begin
                    clr_acc   = 1'b1;
                    state_nxt = LOCK;
                end
            end
            LOCK: begin
                if (!clr)
                    state_nxt = ARMED;
            end
            default: state_nxt = ARMED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ARMED;
            clr_ack <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_ack <= clr_acc;
        end
    end

    // Decode ch_sel into per-channel strobes. An out-of-range ch_sel
    // selects no channel.
    always_comb begin
        clr_sel  = '0;
        load_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == SEL_W'(i)) begin
                clr_sel[i]  = clr_acc;
                load_sel[i] = load;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        cnt_channel #(
            .CNT_W (CNT_W),
            .DEPTH (DEPTH)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr_i    (clr_sel[g]),
            .load_i   (load_sel[g]),
            .load_val (load_val),
            .en_i     (en[g]),
            .count_o  (count[g*CNT_W +: CNT_W]),
            .wrap_o   (wrap[g])
        );
    end

endmodule

// File: doc/addr_seq_counter.md
ADDR_SEQ_COUNTER -- requirements
Module: addr_seq_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of each channel counter.
REQ-002 SHALL have parameter DEPTH, default 256: wrap limit, with a legal range of 2..2**CNT_W.
REQ-003 SHALL have parameter N_CH, default 4: number of independent channels.
REQ-004 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port ch_sel, input, $clog2(N_CH): target channel for clr/load.
REQ-007 SHALL have port clr, input, 1: clear request for the ch_sel channel.
REQ-008 SHALL have port load, input, 1: load request for the ch_sel channel.
REQ-009 SHALL have port load_val, input, CNT_W: value to load.
REQ-010 SHALL have port en, input, N_CH: per-channel advance enable.
REQ-011 SHALL have port count, output, N_CH*CNT_W: channel i occupies bits [i*CNT_W +: CNT_W].
REQ-012 SHALL have port wrap, output, N_CH: one-cycle pulse per channel on wrap.
REQ-013 SHALL have port clr_ack, output, 1: one-cycle acknowledge of an accepted clear.

Function
REQ-014 SHALL resolve per-channel priority each cycle as clr > load > en > hold; clr and load apply only to channel ch_sel.
REQ-015 SHALL implement the clear handshake FSM with states ARMED and LOCK.
- ARMED, clr=1: clear is accepted, channel ch_sel goes to 0 next edge, clr_ack=1 next cycle, FSM goes to LOCK.
- LOCK: clr is ignored; the FSM returns to ARMED on the first cycle clr=0.
REQ-016 SHALL treat clr=1 while in LOCK as not present, so load and en are evaluated as if clr=0.
REQ-017 SHALL make a load take effect on count the next edge, with load_val values >= DEPTH clamped to DEPTH-1.
REQ-018 SHALL, when en[i]=1 and no higher-priority event targets channel i, update count[i] to count[i]+1, or to 0 when count[i]==DEPTH-1.
REQ-019 SHALL assert wrap[i] for exactly the cycle after the 0-transition of REQ-018; clear and load never assert wrap.
REQ-020 SHALL let all channels advance concurrently, with latency of 1 cycle from en to count.
REQ-021 SHALL ignore en[ch_sel] in a cycle where ch_sel is being cleared or loaded.
REQ-022 SHALL keep count values always < DEPTH.

Reset
REQ-023 SHALL, while rst_n=0 at an edge, set all count to 0, wrap to 0, clr_ack to 0, and the FSM to ARMED.
REQ-024 SHALL give reset priority over every in-flight clear, load, or advance, with no pending ack surviving reset.

Configuration
REQ-025 SHALL support macro ADDR_CNT_SAT_EN.
- Defined: a channel at DEPTH-1 with en=1 holds at DEPTH-1, and wrap[i] becomes a level flag, high while count[i]==DEPTH-1.
- Undefined: wrap-around per REQ-018/019.

Structure
REQ-026 SHALL define the FSM state enum (ARMED, LOCK) in package cnn_cnt_pkg.
REQ-027 SHALL instantiate sub-module cnt_channel N_CH times via generate.
- Each instance takes clr_i, load_i, load_val, en_i and produces count_o and wrap_o.
- The FSM, ch_sel decode, and clr_ack live in the top module.

Verification
REQ-028 SHALL cover reset mid-count: DEPTH=256, ch0 counting at 37, rst_n=0 for 1 cycle -> all count=0, wrap=0, clr_ack=0.
REQ-029 SHALL cover wrap: DEPTH=10, en[1]=1 held from 0 for 10 cycles -> count[1] sequence 1..9,0; wrap[1]=1 exactly in the cycle count[1] reads 0.
REQ-030 SHALL cover clear lockout: clr=1, ch_sel=2 held 5 cycles while count[2]=7 and en[2]=1 -> count[2]=0 then 1,2,3,4; clr_ack high 1 cycle only; clr dropped 1 cycle then raised -> second ack.
REQ-031 SHALL cover load clamp and priority: DEPTH=10, load=1, load_val=200, en[0]=1, ch_sel=0 -> count[0]=9; the next cycle with en only -> 0 with wrap[0].
REQ-032 SHALL cover simultaneous events: clr=1 and load=1 with ch_sel=3 in ARMED -> count[3]=0; the same stimulus in LOCK -> count[3]=load_val.
REQ-033 SHALL cover the ADDR_CNT_SAT_EN build: DEPTH=10, en held 15 cycles -> count stays 9, wrap level high from the first 9 onward.
